// File: rtl/ar429_pkg.sv
// Shared ARINC 429 definitions: rate codes, field widths, FSM encoding,
// phase-length lookup and word assembly used by the transmit and receive paths.
package ar429_pkg;

  localparam logic [1:0] AR_MODE_NONE = 2'd0;
  localparam logic [1:0] AR_MODE_12_5 = 2'd1;
  localparam logic [1:0] AR_MODE_50   = 2'd2;
  localparam logic [1:0] AR_MODE_100  = 2'd3;

  localparam int AR_WORD_W   = 32;
  localparam int AR_ADR_W    = 8;
  localparam int AR_DAT_W    = 23;
  localparam int AR_PHASE_W  = 12;
  localparam int AR_BITCNT_W = 6;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HIGH = 2'd1,
    TX_NULL = 2'd2,
    TX_GAP  = 2'd3
  } tx_state_e;

  // Half-bit length in clocks (P = Fclk / line rate); zero for an invalid code.
  function automatic logic [AR_PHASE_W-1:0] ar_period(
    input logic [1:0]  mode,
    input int unsigned fclk,
    input int unsigned v100,
    input int unsigned v50,
    input int unsigned v12
  );
    int unsigned p;
    case (mode)
      AR_MODE_100:  p = fclk / v100;
      AR_MODE_50:   p = fclk / v50;
      AR_MODE_12_5: p = fclk / v12;
      default:      p = 32'd0;
    endcase
    return p[AR_PHASE_W-1:0];
  endfunction

  // Parity bit that makes the full 32-bit word carry an odd number of ones.
  function automatic logic ar_odd_parity(input logic [AR_WORD_W-1:1] payload);
    return ~^payload;
  endfunction

  // Label in the top byte MSB first, data LSB first below it, parity in bit 0.
  function automatic logic [AR_WORD_W-1:0] ar_build_word(
    input logic [AR_ADR_W-1:0] adr,
    input logic [AR_DAT_W-1:0] dat
  );
    logic [AR_WORD_W-1:0] w;
    w = {adr, 24'd0};
    for (int k = 0; k < AR_DAT_W; k++) begin
      w[AR_DAT_W-k] = dat[k];
    end
    w[0] = ar_odd_parity(w[AR_WORD_W-1:1]);
    return w;
  endfunction

endpackage

// File: rtl/ar_txd_if.sv
// Transmit request/line bundle between a word source and the ARINC 429 transmitter.
interface ar_txd_if;

  logic        st;
  logic [1:0]  mode;
  logic [7:0]  sr_adr;
  logic [22:0] sr_dat;
  logic        txd1;
  logic        txd0;
  logic        busy;
  logic        ce_tx;

  modport master (
    output st, mode, sr_adr, sr_dat,
    input  txd1, txd0, busy, ce_tx
  );

  modport slave (
    input  st, mode, sr_adr, sr_dat,
    output txd1, txd0, busy, ce_tx
  );

endinterface

// File: rtl/ar_phase_timer.sv
// Down-counter that times one HIGH/NULL/gap phase; reloads to P-1 on load_i
// and parks at zero, where phase_end_o marks the final cycle of the phase.
module ar_phase_timer
  import ar429_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [AR_PHASE_W-1:0] period_i,
  output logic                  phase_end_o,
  output logic                  pre_end_o
);

  logic [AR_PHASE_W-1:0] cnt_q;
  logic [AR_PHASE_W-1:0] cnt_d;

  // Next count: reload, decrement, or hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = period_i - 12'd1;
    end else if (cnt_q != 12'd0) begin
      cnt_d = cnt_q - 12'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 12'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_end_o = (cnt_q == 12'd0);
  assign pre_end_o   = (cnt_q == 12'd1);

endmodule

// File: rtl/ar_txd.sv
// ARINC 429 word transmitter: captures label/data on a start strobe and sends the
// parity-completed word as return-to-zero pulses on txd1/txd0, followed by a null gap.
module ar_txd
  import ar429_pkg::*;
#(
  parameter int unsigned Fclk     = 50000000,
  parameter int unsigned V100kb   = 100000,
  parameter int unsigned V50kb    = 50000,
  parameter int unsigned V12_5kb  = 12500,
  parameter int unsigned GAP_BITS = 4
) (
  input logic     clk,
  input logic     rst_n,
  ar_txd_if.slave bus
);

  localparam logic [AR_BITCNT_W-1:0] LAST_BIT = 6'd31;
  localparam logic [AR_BITCNT_W-1:0] LAST_GAP = AR_BITCNT_W'(2 * GAP_BITS - 1);

  tx_state_e              state_q, state_d;
  logic [AR_WORD_W-1:0]   shift_q, shift_d;
  logic [AR_BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [1:0]             mode_q, mode_d;
  logic                   txd1_q, txd1_d;
  logic                   txd0_q, txd0_d;
  logic                   busy_q, busy_d;
  logic                   ce_tx_q, ce_tx_d;

  logic                   start_s;
  logic                   load_s;
  logic [AR_PHASE_W-1:0]  period_s;
  logic                   phase_end_s;
  logic                   pre_end_s;

  assign start_s = (state_q == TX_IDLE) && bus.st && (bus.mode != AR_MODE_NONE);

  ar_phase_timer u_phase_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load_s),
    .period_i    (period_s),
    .phase_end_o (phase_end_s),
    .pre_end_o   (pre_end_s)
  );

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= TX_IDLE;
      shift_q   <= 32'd0;
      bit_cnt_q <= 6'd0;
      mode_q    <= AR_MODE_NONE;
      txd1_q    <= 1'b0;
      txd0_q    <= 1'b0;
      busy_q    <= 1'b0;
      ce_tx_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      mode_q    <= mode_d;
      txd1_q    <= txd1_d;
      txd0_q    <= txd0_d;
      busy_q    <= busy_d;
      ce_tx_q   <= ce_tx_d;
    end
  end

  // Next state; the bit counter is reused to count gap phases.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    mode_d    = mode_q;
    load_s    = 1'b0;
    period_s  = ar_period(mode_q, Fclk, V100kb, V50kb, V12_5kb);
    case (state_q)
      TX_IDLE: begin
        if (start_s) begin
          state_d   = TX_HIGH;
          shift_d   = ar_build_word(bus.sr_adr, bus.sr_dat);
          bit_cnt_d = 6'd0;
          mode_d    = bus.mode;
          period_s  = ar_period(bus.mode, Fclk, V100kb, V50kb, V12_5kb);
          load_s    = 1'b1;
        end else begin
          state_d = TX_IDLE;
        end
      end
      TX_HIGH: begin
        if (phase_end_s) begin
          state_d = TX_NULL;
          load_s  = 1'b1;
        end else begin
          state_d = TX_HIGH;
        end
      end
      TX_NULL: begin
        if (phase_end_s && (bit_cnt_q == LAST_BIT)) begin
          state_d   = TX_GAP;
          bit_cnt_d = 6'd0;
          load_s    = 1'b1;
        end else if (phase_end_s) begin
          state_d   = TX_HIGH;
          bit_cnt_d = bit_cnt_q + 6'd1;
          shift_d   = {shift_q[AR_WORD_W-2:0], 1'b0};
          load_s    = 1'b1;
        end else begin
          state_d = TX_NULL;
        end
      end
      TX_GAP: begin
        if (phase_end_s && (bit_cnt_q == LAST_GAP)) begin
          state_d = TX_IDLE;
        end else if (phase_end_s) begin
          bit_cnt_d = bit_cnt_q + 6'd1;
          load_s    = 1'b1;
        end else begin
          state_d = TX_GAP;
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  // Outputs follow the next state so they are registered yet aligned with it.
  always_comb begin
    txd1_d  = 1'b0;
    txd0_d  = 1'b0;
    busy_d  = 1'b0;
    ce_tx_d = 1'b0;
    if (state_d == TX_HIGH) begin
      txd1_d = shift_d[AR_WORD_W-1];
      txd0_d = ~shift_d[AR_WORD_W-1];
    end else begin
      txd1_d = 1'b0;
      txd0_d = 1'b0;
    end
    if (state_d != TX_IDLE) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
    if ((state_q == TX_GAP) && (bit_cnt_q == LAST_GAP) && pre_end_s) begin
      ce_tx_d = 1'b1;
    end else begin
      ce_tx_d = 1'b0;
    end
  end

  assign bus.txd1  = txd1_q;
  assign bus.txd0  = txd0_q;
  assign bus.busy  = busy_q;
  assign bus.ce_tx = ce_tx_q;

endmodule

// File: doc/ar_txd.md
# ar_txd

ARINC 429 word transmitter: accepts an 8-bit label/address and a 23-bit data field with a one-cycle start strobe, appends odd parity, and drives the 32-bit word serially as return-to-zero pulses on a differential pair of line-driver enables (`txd1`/`txd0`). It is the transmit counterpart of `AR_RXD`, using the same rate codes, bit order, parity and pulse-length convention, so that `ar_txd` looped into `AR_RXD` yields `ce_wr` with identical `sr_adr`/`sr_dat`.

## Interface
- `Fclk`, 50000000, system clock frequency in Hz
- `V100kb`, 100000; `V50kb`, 50000; `V12_5kb`, 12500; line rates in bit/s
- `GAP_BITS`, 4, inter-word null time in bit times (1 bit time = 2·P clocks)
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `st`  in  1  start strobe, sampled only when `busy`=0
- `mode`  in  2  rate code: 1 = 12.5 kb/s, 2 = 50 kb/s, 3 = 100 kb/s, 0 = invalid
- `sr_adr`  in  8  label/address to send
- `sr_dat`  in  23  data field to send
- `txd1`  out  1  "one" line pulse
- `txd0`  out  1  "zero" line pulse
- `busy`  out  1  word or inter-word gap in progress
- `ce_tx`  out  1  one-cycle pulse: word and gap complete

## Operation
- P = Fclk/V (500 / 1000 / 4000 clocks for modes 3 / 2 / 1); selected at `st` and held for the whole word.
- On `st`=1, `busy`=0, `mode`≠0: capture `sr_adr`, `sr_dat`, `mode`; build word W[31:0]: W[31:24]=`sr_adr`, W[23-k]=`sr_dat[k]` for k=0..22, W[0]=~^W[31:1] (odd parity over 32 bits).
- `st` with `mode`=0, or while `busy`=1: ignored, no state change.
- Bits sent W[31] first to W[0] last (i.e. `sr_adr[7]`..`sr_adr[0]`, `sr_dat[0]`..`sr_dat[22]`, parity).
- Each bit: HIGH phase P clocks (`txd1`=bit, `txd0`=~bit), then NULL phase P clocks (both 0).
- After bit 0 NULL phase: GAP of GAP_BITS·2·P clocks, both lines 0.
- FSM: IDLE → (valid `st`) HIGH → NULL → HIGH … (32 bits) → GAP → IDLE.
- `txd1` and `txd0` are never 1 simultaneously, in any state, including reset.
- Phase counter 12 bits (max P−1 = 3999); bit counter 6 bits; gap counted in NULL-length phases (2·GAP_BITS phases) using the same phase counter.

## Timing
- Reset (`rst_n`=0 at an edge): next cycle IDLE, `txd1`=`txd0`=`busy`=`ce_tx`=0, counters 0, captured word 0.
- Reset mid-word: line returns to null immediately on the next edge; partial word is abandoned, not resumed.
- `st` at cycle 0 → `busy`=1 and first HIGH phase visible from cycle 1.
- Word = 64·P clocks, gap = 2·GAP_BITS·P clocks; `busy` high exactly (64+2·GAP_BITS)·P cycles (36000 at mode 3).
- `ce_tx` high in the last `busy` cycle only; `busy`=0 the next cycle.
- Back-to-back: `st` in the first cycle with `busy`=0 starts the next word at the following cycle; the gap is therefore never shortened.
- `st` in the same cycle as `ce_tx`: ignored (`busy` still 1).
- Inputs `sr_adr`/`sr_dat`/`mode` may change freely after the capture cycle.

## Structure
- Shared package `ar429_pkg`: rate-code constants (`AR_MODE_12_5`=1, `AR_MODE_50`=2, `AR_MODE_100`=3), word width 32, field widths 8/23, function returning P for a rate code and `Fclk`, parity function; `AR_RXD` rework reuses it.
- One sub-module: `ar_phase_timer` (loads P, counts down, emits phase-end pulse); FSM, shift register and parity in `ar_txd`.

## Test plan
- Reset: hold `rst_n`=0 with `st`=1, `mode`=3 → all outputs 0 throughout; release → IDLE, no transmission.
- Mode 3, `sr_adr`=8'hA5, `sr_dat`=23'h000001 → pulses on txd1 for 1,0,1,0,0,1,0,1, then txd1 (dat[0]), 22 txd0 pulses, parity 0 on txd0; each HIGH 500 clk, NULL 500 clk; `ce_tx` at cycle 36000.
- Mode 2, `sr_adr`=0, `sr_dat`=0 → 31 txd0 pulses then parity on txd1, HIGH 1000 clk; loopback into `AR_RXD` → `ce_wr`=1, `sr_adr`=0, `sr_dat`=0.
- `st` mid-word and in the `ce_tx` cycle → ignored; `st` first cycle `busy`=0 → new word starts next cycle, gap = 4000 null clocks at mode 3.
- `st` with `mode`=0 → `busy` stays 0; mode 1 → HIGH phase 4000 clk exactly (12-bit counter no wrap).
- `rst_n`=0 during bit 10 HIGH phase → lines 0 next edge, `busy`=0, no `ce_tx`; loopback receiver reports no `ce_wr`.
